axi_lite_uart_arb: RTL and testbench
====================================

// Module: axi_lite_uart_arb
// PURPOSE
//  Two-requester AXI4-Lite master arbiter in front of the UART register slave (S_AXI_* port).
//  Accepts single-beat read/write commands on two simple req/rsp ports, grants round-robin,
//  runs one full AXI4-Lite transaction at a time and returns data/response to the owner.
//  Lets CPU-side and DMA-side logic share one UART without a full interconnect.
// PARAMETERS
//  P_ADDR_WIDTH  32  address width of requester and M_AXI address buses
//  P_DATA_WIDTH  32  data width of requester and M_AXI data buses; WSTRB = P_DATA_WIDTH/8
// PORTS
//  ACLK          in   1    clock, all logic on rising edge
//  ARESETn       in   1    asynchronous, active-low reset
//  REQn_VALID    in   1    (n=0,1) command present; held with fields until REQn_READY
//  REQn_WE       in   1    1=write, 0=read
//  REQn_ADDR     in   AW   byte address
//  REQn_WDATA    in   DW   write data (ignored for reads)
//  REQn_WSTRB    in   DW/8 write strobes (ignored for reads)
//  REQn_READY    out  1    one-cycle pulse: command accepted/latched
//  RSPn_VALID    out  1    one-cycle pulse: transaction complete
//  RSPn_RDATA    out  DW   read data (0 for writes), valid with RSPn_VALID
//  RSPn_RESP     out  2    BRESP/RRESP from slave, valid with RSPn_VALID
//  M_AXI_AW{VALID,ADDR,PROT} out, AWREADY in; M_AXI_W{VALID,DATA,STRB} out, WREADY in
//  M_AXI_B{VALID,RESP} in, BREADY out; M_AXI_AR{VALID,ADDR,PROT} out, ARREADY in
//  M_AXI_R{VALID,DATA,RESP} in, RREADY out   (widths per AXI4-Lite, AW/DW above)
// BEHAVIOUR
//  Reset: every output 0 (valids, readies, addr/data/strb, REQ_READY, RSP_*); FSM=IDLE;
//   last_grant=1 so requester 0 wins the first tie. AWPROT/ARPROT constant 3'b000.
//  FSM: IDLE -> W_ADDR (write) | R_ADDR (read) ; W_ADDR -> W_RESP -> DONE ; R_ADDR -> R_DATA -> DONE -> IDLE.
//  IDLE: if any REQn_VALID, grant: only one valid -> that one; both -> the one != last_grant.
//   Same cycle: REQn_READY=1 (registered pulse visible cycle T), command latched, last_grant=n.
//  W_ADDR (from T+1): AWVALID=WVALID=1 with latched ADDR/DATA/STRB; each drops on its own
//   handshake edge (VALID&READY); leave when both done (either order or same cycle).
//  W_RESP: BREADY=1; on BVALID&BREADY capture BRESP, BREADY=0, go DONE.
//  R_ADDR (from T+1): ARVALID=1 until ARVALID&ARREADY; R_DATA: RREADY=1 until RVALID&RREADY,
//   capture RDATA/RRESP.
//  DONE: RSPn_VALID=1 for exactly one cycle to the granted owner only, RDATA (0 on write),
//   RESP; other RSP port stays 0. Back to IDLE; new grant possible the next cycle.
//  Latency with zero-wait slave: write READY at T, AW/W handshake T+1, B T+2, RSP T+3;
//   read same (AR T+1, R T+2, RSP T+3). Min issue interval 4 cycles.
//  AXI rules: never deassert a VALID before its handshake; address/data stable while VALID;
//   exactly one transaction outstanding; slave BRESP/RRESP propagated unmodified (no remap).
//  Losing requester simply waits (VALID held); no starvation: strict alternation when both held.
//  REQ_VALID dropped while not granted: nothing issued. Inputs in non-IDLE states ignored.
//  Reset mid-transaction: outputs 0 immediately (async), no RSP pulse for aborted command.
// TESTING
//  1 REQ0 write ADDR=2 WDATA=6 WSTRB=F, zero-wait slave -> AW/W valid T+1 with 2/6/F,
//    RSP0_VALID pulse at T+3 RESP=00 RDATA=0; RSP1_VALID never 1.
//  2 REQ1 read ADDR=1, slave RDATA=0x5A RRESP=00 -> ARADDR=1, RSP1_VALID once, RDATA=0x5A.
//  3 REQ0 and REQ1 held valid from reset release (4 writes each) -> grant order 0,1,0,1,...;
//    every command accepted once; RSP owner matches grant.
//  4 Slave WREADY after 1 cycle, AWREADY after 3, BRESP=10 -> WVALID drops first, AWVALID later,
//    single B handshake, RSP0_RESP=10.
//  5 ARESETn low during R_DATA (RVALID withheld) -> all outputs 0 at once, no RSP pulse;
//    after release REQ1 read completes normally and requester 0 wins a tie.
//  6 Protocol monitor throughout: no VALID drop before READY, no second AW/AR while one open.

Source files
------------

// File: rtl/axi_lite_uart_arb.sv
// Round-robin arbiter letting two single-beat requesters share one AXI4-Lite slave.
// One transaction is in flight at a time; the response is pulsed back to the owner only.
module axi_lite_uart_arb #(
  parameter int P_ADDR_WIDTH = 32,
  parameter int P_DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      REQ0_VALID,
  input  logic                      REQ0_WE,
  input  logic [P_ADDR_WIDTH-1:0]   REQ0_ADDR,
  input  logic [P_DATA_WIDTH-1:0]   REQ0_WDATA,
  input  logic [P_DATA_WIDTH/8-1:0] REQ0_WSTRB,
  output logic                      REQ0_READY,
  output logic                      RSP0_VALID,
  output logic [P_DATA_WIDTH-1:0]   RSP0_RDATA,
  output logic [1:0]                RSP0_RESP,
  input  logic                      REQ1_VALID,
  input  logic                      REQ1_WE,
  input  logic [P_ADDR_WIDTH-1:0]   REQ1_ADDR,
  input  logic [P_DATA_WIDTH-1:0]   REQ1_WDATA,
  input  logic [P_DATA_WIDTH/8-1:0] REQ1_WSTRB,
  output logic                      REQ1_READY,
  output logic                      RSP1_VALID,
  output logic [P_DATA_WIDTH-1:0]   RSP1_RDATA,
  output logic [1:0]                RSP1_RESP,
  output logic                      M_AXI_AWVALID,
  output logic [P_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  input  logic                      M_AXI_AWREADY,
  output logic                      M_AXI_WVALID,
  output logic [P_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [P_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  input  logic                      M_AXI_WREADY,
  input  logic                      M_AXI_BVALID,
  input  logic [1:0]                M_AXI_BRESP,
  output logic                      M_AXI_BREADY,
  output logic                      M_AXI_ARVALID,
  output logic [P_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  input  logic                      M_AXI_ARREADY,
  input  logic                      M_AXI_RVALID,
  input  logic [P_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  output logic                      M_AXI_RREADY,
  output logic [2:0]                dbg_state
);
  localparam int SW = P_DATA_WIDTH / 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_W_ADDR = 3'd1;
  localparam logic [2:0] S_W_RESP = 3'd2;
  localparam logic [2:0] S_R_ADDR = 3'd3;
  localparam logic [2:0] S_R_DATA = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]              state;
  logic                    last_grant;
  logic                    owner;
  logic [P_ADDR_WIDTH-1:0] cmd_addr;
  logic [P_DATA_WIDTH-1:0] cmd_wdata;
  logic [SW-1:0]           cmd_wstrb;
  logic                    req0_ready_q, req1_ready_q;
  logic                    rsp0_valid_q, rsp1_valid_q;
  logic [P_DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]              rsp_resp;
  logic                    aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q;
  logic                    aw_done, w_done;

  logic                    grant_any, grant_sel, sel_we, launch;
  logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [P_ADDR_WIDTH-1:0] sel_addr;
  logic [P_DATA_WIDTH-1:0] sel_wdata;
  logic [SW-1:0]           sel_wstrb;

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // VALID and READY are both high; a VALID we drive never falls and its payload never
  // changes until that edge, and the requester must hold REQn_* stable until REQn_READY.
  always_comb begin
    grant_any = REQ0_VALID | REQ1_VALID;
    if (REQ0_VALID && REQ1_VALID) grant_sel = ~last_grant;
    else                          grant_sel = REQ1_VALID;
    sel_we    = grant_sel ? REQ1_WE    : REQ0_WE;
    sel_addr  = grant_sel ? REQ1_ADDR  : REQ0_ADDR;
    sel_wdata = grant_sel ? REQ1_WDATA : REQ0_WDATA;
    sel_wstrb = grant_sel ? REQ1_WSTRB : REQ0_WSTRB;
  end

  // The REQ_READY pulse marks the first cycle of the address state; channels open one cycle later.
  assign launch = req0_ready_q | req1_ready_q;
  assign aw_hs  = aw_valid_q & M_AXI_AWREADY;
  assign w_hs   = w_valid_q  & M_AXI_WREADY;
  assign b_hs   = b_ready_q  & M_AXI_BVALID;
  assign ar_hs  = ar_valid_q & M_AXI_ARREADY;
  assign r_hs   = r_ready_q  & M_AXI_RVALID;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state        <= S_IDLE;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      cmd_wstrb    <= '0;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_rdata    <= '0;
      rsp_resp     <= 2'b00;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      b_ready_q    <= 1'b0;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
    end else begin
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      case (state)
        // DONE arbitrates like IDLE so back-to-back commands issue every 4 cycles.
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (grant_any) begin
            owner        <= grant_sel;
            last_grant   <= grant_sel;
            req0_ready_q <= ~grant_sel;
            req1_ready_q <= grant_sel;
            cmd_addr     <= sel_addr;
            cmd_wdata    <= sel_wdata;
            cmd_wstrb    <= sel_wstrb;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            state        <= sel_we ? S_W_ADDR : S_R_ADDR;
          end
        end
        S_W_ADDR: begin
          if (launch) begin
            aw_valid_q <= 1'b1;
            w_valid_q  <= 1'b1;
          end else begin
            if (aw_hs) begin
              aw_valid_q <= 1'b0;
              aw_done    <= 1'b1;
            end
            if (w_hs) begin
              w_valid_q <= 1'b0;
              w_done    <= 1'b1;
            end
            if ((aw_done | aw_hs) && (w_done | w_hs)) begin
              b_ready_q <= 1'b1;
              state     <= S_W_RESP;
            end
          end
        end
        S_W_RESP: begin
          if (b_hs) begin
            b_ready_q    <= 1'b0;
            rsp_resp     <= M_AXI_BRESP;
            rsp_rdata    <= '0;
            rsp0_valid_q <= ~owner;
            rsp1_valid_q <= owner;
            state        <= S_DONE;
          end
        end
        S_R_ADDR: begin
          if (launch) begin
            ar_valid_q <= 1'b1;
          end else if (ar_hs) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state      <= S_R_DATA;
          end
        end
        S_R_DATA: begin
          if (r_hs) begin
            r_ready_q    <= 1'b0;
            rsp_resp     <= M_AXI_RRESP;
            rsp_rdata    <= M_AXI_RDATA;
            rsp0_valid_q <= ~owner;
            rsp1_valid_q <= owner;
            state        <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign REQ0_READY    = req0_ready_q;
  assign REQ1_READY    = req1_ready_q;
  assign RSP0_VALID    = rsp0_valid_q;
  assign RSP1_VALID    = rsp1_valid_q;
  assign RSP0_RDATA    = rsp0_valid_q ? rsp_rdata : '0;
  assign RSP1_RDATA    = rsp1_valid_q ? rsp_rdata : '0;
  assign RSP0_RESP     = rsp0_valid_q ? rsp_resp : 2'b00;
  assign RSP1_RESP     = rsp1_valid_q ? rsp_resp : 2'b00;
  assign M_AXI_AWVALID = aw_valid_q;
  assign M_AXI_AWADDR  = cmd_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WVALID  = w_valid_q;
  assign M_AXI_WDATA   = cmd_wdata;
  assign M_AXI_WSTRB   = cmd_wstrb;
  assign M_AXI_BREADY  = b_ready_q;
  assign M_AXI_ARVALID = ar_valid_q;
  assign M_AXI_ARADDR  = cmd_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = r_ready_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_axi_lite_uart_arb.sv
// Directed bench for axi_lite_uart_arb: negedge-driven AXI4-Lite slave model with
// configurable wait states, a rising-edge protocol monitor, and a linear test sequence.
module tb_axi_lite_uart_arb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          REQ0_VALID, REQ0_WE, REQ0_READY, RSP0_VALID;
  logic [AW-1:0] REQ0_ADDR;
  logic [DW-1:0] REQ0_WDATA, RSP0_RDATA;
  logic [3:0]    REQ0_WSTRB;
  logic [1:0]    RSP0_RESP;
  logic          REQ1_VALID, REQ1_WE, REQ1_READY, RSP1_VALID;
  logic [AW-1:0] REQ1_ADDR;
  logic [DW-1:0] REQ1_WDATA, RSP1_RDATA;
  logic [3:0]    REQ1_WSTRB;
  logic [1:0]    RSP1_RESP;
  logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
  logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]    M_AXI_WSTRB;
  logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
  logic          M_AXI_RVALID, M_AXI_RREADY;
  logic [2:0]    dbg_state;

  axi_lite_uart_arb #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .REQ0_VALID(REQ0_VALID), .REQ0_WE(REQ0_WE), .REQ0_ADDR(REQ0_ADDR),
    .REQ0_WDATA(REQ0_WDATA), .REQ0_WSTRB(REQ0_WSTRB), .REQ0_READY(REQ0_READY),
    .RSP0_VALID(RSP0_VALID), .RSP0_RDATA(RSP0_RDATA), .RSP0_RESP(RSP0_RESP),
    .REQ1_VALID(REQ1_VALID), .REQ1_WE(REQ1_WE), .REQ1_ADDR(REQ1_ADDR),
    .REQ1_WDATA(REQ1_WDATA), .REQ1_WSTRB(REQ1_WSTRB), .REQ1_READY(REQ1_READY),
    .RSP1_VALID(RSP1_VALID), .RSP1_RDATA(RSP1_RDATA), .RSP1_RESP(RSP1_RESP),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WDATA(M_AXI_WDATA),
    .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RREADY(M_AXI_RREADY), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 ACLK = ~ACLK;

  // ---------------- slave model (drives on falling edges) ----------------
  int          aw_lat, w_lat;
  logic [1:0]  b_resp, r_resp;
  logic [31:0] r_data;
  logic        r_hold;
  int          aw_cnt, w_cnt;
  logic        aw_pend, w_pend, b_pend, ar_pend, r_pend, aw_got, w_got, ar_got;

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
      M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
      aw_cnt = 0; w_cnt = 0; aw_got = 0; w_got = 0; ar_got = 0;
      aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
    end else begin
      // handshakes that completed at the rising edge just passed
      if (aw_pend) aw_got = 1;
      if (w_pend)  w_got  = 1;
      if (ar_pend) ar_got = 1;
      if (b_pend)  M_AXI_BVALID = 0;
      if (r_pend)  M_AXI_RVALID = 0;
      M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_lat);
      aw_cnt = M_AXI_AWVALID ? aw_cnt + 1 : 0;
      M_AXI_WREADY = M_AXI_WVALID && (w_cnt >= w_lat);
      w_cnt = M_AXI_WVALID ? w_cnt + 1 : 0;
      M_AXI_ARREADY = M_AXI_ARVALID;
      if (aw_got && w_got && !M_AXI_BVALID) begin
        M_AXI_BVALID = 1; M_AXI_BRESP = b_resp; aw_got = 0; w_got = 0;
      end
      if (ar_got && !M_AXI_RVALID && !r_hold) begin
        M_AXI_RVALID = 1; M_AXI_RDATA = r_data; M_AXI_RRESP = r_resp; ar_got = 0;
      end
      aw_pend = M_AXI_AWVALID && M_AXI_AWREADY;
      w_pend  = M_AXI_WVALID && M_AXI_WREADY;
      ar_pend = M_AXI_ARVALID && M_AXI_ARREADY;
      b_pend  = M_AXI_BVALID && M_AXI_BREADY;
      r_pend  = M_AXI_RVALID && M_AXI_RREADY;
    end
  end

  // ---------------- protocol monitor (samples pre-edge values) ----------------
  int          mon_err = 0;
  int          tot_rsp0 = 0, tot_rsp1 = 0, tot_aw = 0, tot_w = 0, tot_b = 0, tot_ar = 0;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, txn_open;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  always @(posedge ACLK) begin
    if (!ARESETn) begin
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; txn_open = 0;
    end else begin
      if (p_awv && !p_awr && (M_AXI_AWVALID !== 1'b1 || M_AXI_AWADDR !== p_awaddr)) begin
        mon_err++; $display("FAIL mon_aw_stable: AWVALID %b AWADDR %0h, need 1 / %0h", M_AXI_AWVALID, M_AXI_AWADDR, p_awaddr);
      end
      if (p_wv && !p_wr && (M_AXI_WVALID !== 1'b1 || M_AXI_WDATA !== p_wdata)) begin
        mon_err++; $display("FAIL mon_w_stable: WVALID %b WDATA %0h, need 1 / %0h", M_AXI_WVALID, M_AXI_WDATA, p_wdata);
      end
      if (p_arv && !p_arr && (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== p_araddr)) begin
        mon_err++; $display("FAIL mon_ar_stable: ARVALID %b ARADDR %0h, need 1 / %0h", M_AXI_ARVALID, M_AXI_ARADDR, p_araddr);
      end
      if ((M_AXI_AWVALID && M_AXI_ARVALID) || (txn_open && (M_AXI_AWVALID || M_AXI_ARVALID))) begin
        mon_err++; $display("FAIL mon_outstanding: second address while a transaction is open");
      end
      if (RSP0_VALID && RSP1_VALID) begin
        mon_err++; $display("FAIL mon_rsp_both: both RSP valids high, need at most one");
      end
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin tot_aw++; txn_open = 1; end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin tot_ar++; txn_open = 1; end
      if (M_AXI_WVALID && M_AXI_WREADY) tot_w++;
      if (M_AXI_BVALID && M_AXI_BREADY) begin tot_b++; txn_open = 0; end
      if (M_AXI_RVALID && M_AXI_RREADY) txn_open = 0;
      if (RSP0_VALID) tot_rsp0++;
      if (RSP1_VALID) tot_rsp1++;
      p_awv = M_AXI_AWVALID; p_awr = M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
      p_wv = M_AXI_WVALID; p_wr = M_AXI_WREADY; p_wdata = M_AXI_WDATA;
      p_arv = M_AXI_ARVALID; p_arr = M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
    end
  end

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive_req(input int n, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
    if (n == 0) begin
      REQ0_VALID = 1; REQ0_WE = we; REQ0_ADDR = addr; REQ0_WDATA = wdata; REQ0_WSTRB = wstrb;
    end else begin
      REQ1_VALID = 1; REQ1_WE = we; REQ1_ADDR = addr; REQ1_WDATA = wdata; REQ1_WSTRB = wstrb;
    end
  endtask

  int         s_rsp0, s_rsp1, s_aw, s_w, s_b, s_ar;
  int         g, nrsp, i0, i1;
  logic [7:0] gbits, exp_owner;
  logic [1:0] first_rdy, r0_resp, r1_resp;
  logic       got0, got1;
  logic [31:0] r1_data;

  task automatic snap();
    s_rsp0 = tot_rsp0; s_rsp1 = tot_rsp1; s_aw = tot_aw; s_w = tot_w; s_b = tot_b; s_ar = tot_ar;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ARESETn = 0;
    REQ0_VALID = 0; REQ0_WE = 0; REQ0_ADDR = 0; REQ0_WDATA = 0; REQ0_WSTRB = 0;
    REQ1_VALID = 0; REQ1_WE = 0; REQ1_ADDR = 0; REQ1_WDATA = 0; REQ1_WSTRB = 0;
    aw_lat = 0; w_lat = 0; b_resp = 2'b00; r_resp = 2'b00; r_data = 32'h0; r_hold = 0;
    repeat (3) @(negedge ACLK);
    check("rst_req0_ready", REQ0_READY, 0);
    check("rst_rsp0_valid", RSP0_VALID, 0);
    check("rst_awvalid", M_AXI_AWVALID, 0);
    check("rst_arvalid", M_AXI_ARVALID, 0);
    check("rst_bready_rready", {M_AXI_BREADY, M_AXI_RREADY}, 0);
    check("rst_awaddr_wdata", {M_AXI_AWADDR, M_AXI_WDATA}, 0);
    ARESETn = 1;
    @(negedge ACLK);

    // Test 1: REQ0 write, zero-wait slave
    snap();
    drive_req(0, 1'b1, 32'h2, 32'h6, 4'hF);
    @(negedge ACLK);  // T
    check("t1_ready_T", {REQ1_READY, REQ0_READY}, 2'b01);
    check("t1_aw_not_yet", M_AXI_AWVALID, 0);
    REQ0_VALID = 0;
    @(negedge ACLK);  // T+1
    check("t1_aw_w_valid", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
    check("t1_aw_fields", {M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_AWPROT}, {32'h2, 32'h6, 4'hF, 3'b000});
    @(negedge ACLK);  // T+2
    check("t1_bready_T2", {M_AXI_BREADY, M_AXI_AWVALID, M_AXI_WVALID, RSP0_VALID}, 4'b1000);
    @(negedge ACLK);  // T+3
    check("t1_rsp0_T3", {RSP1_VALID, RSP0_VALID, RSP0_RESP}, 4'b0100);
    check("t1_rsp0_rdata", RSP0_RDATA, 0);
    @(negedge ACLK);  // T+4
    check("t1_rsp0_pulse_once", RSP0_VALID, 0);
    check("t1_counts", {8'(tot_rsp0 - s_rsp0), 8'(tot_rsp1 - s_rsp1), 8'(tot_aw - s_aw), 8'(tot_b - s_b)}, 32'h01000101);

    // Test 2: REQ1 read, slave returns 0x5A
    snap();
    r_data = 32'h5A;
    drive_req(1, 1'b0, 32'h1, 32'h0, 4'h0);
    @(negedge ACLK);  // T
    check("t2_ready_T", {REQ1_READY, REQ0_READY}, 2'b10);
    REQ1_VALID = 0;
    @(negedge ACLK);  // T+1
    check("t2_ar", {M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_AWVALID}, {1'b1, 32'h1, 3'b000, 1'b0});
    @(negedge ACLK);  // T+2
    check("t2_rready_T2", {M_AXI_RREADY, M_AXI_ARVALID}, 2'b10);
    @(negedge ACLK);  // T+3
    check("t2_rsp1_T3", {RSP0_VALID, RSP1_VALID, RSP1_RESP}, 4'b0100);
    check("t2_rsp1_rdata", RSP1_RDATA, 32'h5A);
    @(negedge ACLK);
    check("t2_counts", {8'(tot_rsp0 - s_rsp0), 8'(tot_rsp1 - s_rsp1), 8'(tot_ar - s_ar)}, 24'h000101);

    // Test 3: both requesters hold valid from reset release, 4 writes each
    ARESETn = 0;
    drive_req(0, 1'b1, 32'h100, 32'hA0, 4'hF);
    drive_req(1, 1'b1, 32'h200, 32'hB0, 4'hF);
    repeat (2) @(negedge ACLK);
    check("t3_rst_readies", {REQ1_READY, REQ0_READY}, 2'b00);
    ARESETn = 1;
    snap();
    g = 0; nrsp = 0; gbits = '0; i0 = 0; i1 = 0;
    for (int c = 0; c < 200 && nrsp < 8; c++) begin
      @(negedge ACLK);
      if (REQ0_READY === 1'b1) begin
        if (g < 8) gbits[g] = 1'b0;
        g++; exp_q.push_back(8'd0); i0++;
        if (i0 < 4) REQ0_ADDR = 32'h100 + i0; else REQ0_VALID = 0;
      end
      if (REQ1_READY === 1'b1) begin
        if (g < 8) gbits[g] = 1'b1;
        g++; exp_q.push_back(8'd1); i1++;
        if (i1 < 4) REQ1_ADDR = 32'h200 + i1; else REQ1_VALID = 0;
      end
      if (RSP0_VALID === 1'b1 || RSP1_VALID === 1'b1) begin
        nrsp++;
        exp_owner = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
        check("t3_rsp_owner", {7'd0, RSP1_VALID}, exp_owner);
      end
    end
    check("t3_grant_count", g, 8);
    check("t3_grant_order", gbits, 8'hAA);
    check("t3_rsp_count", nrsp, 8);
    check("t3_queue_empty", exp_q.size(), 0);
    check("t3_b_count", tot_b - s_b, 8);
    @(negedge ACLK);

    // Test 4: WREADY after 1 cycle, AWREADY after 3, BRESP=SLVERR
    snap();
    aw_lat = 3; w_lat = 1; b_resp = 2'b10;
    drive_req(0, 1'b1, 32'h4, 32'h11, 4'h3);
    @(negedge ACLK);  // T
    check("t4_ready", REQ0_READY, 1);
    REQ0_VALID = 0;
    @(negedge ACLK);  // T+1
    check("t4_both_valid_T1", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
    @(negedge ACLK);  // T+2
    check("t4_both_valid_T2", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
    @(negedge ACLK);  // T+3
    check("t4_w_dropped_first", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b100);
    @(negedge ACLK);  // T+4
    check("t4_aw_still_valid", M_AXI_AWVALID, 1);
    @(negedge ACLK);  // T+5
    check("t4_aw_dropped", {M_AXI_AWVALID, M_AXI_BREADY}, 2'b01);
    @(negedge ACLK);  // T+6
    check("t4_rsp0", {RSP0_VALID, RSP0_RESP, RSP1_VALID}, 4'b1100);
    @(negedge ACLK);
    check("t4_single_b", {8'(tot_b - s_b), 8'(tot_aw - s_aw), 8'(tot_w - s_w)}, 24'h010101);
    aw_lat = 0; w_lat = 0; b_resp = 2'b00;

    // Test 5: reset while waiting for read data
    snap();
    r_hold = 1;
    drive_req(0, 1'b0, 32'h5, 32'h0, 4'h0);
    @(negedge ACLK);  // T
    check("t5_ready", REQ0_READY, 1);
    REQ0_VALID = 0;
    repeat (3) @(negedge ACLK);  // T+3, RVALID withheld
    check("t5_waiting_rdata", {M_AXI_RREADY, M_AXI_ARVALID}, 2'b10);
    #2 ARESETn = 0;
    #1;
    check("t5_async_clear", {M_AXI_RREADY, M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_BREADY, RSP0_VALID, RSP1_VALID}, 6'b0);
    check("t5_async_addr", M_AXI_ARADDR, 0);
    r_hold = 0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1;
    repeat (3) @(negedge ACLK);
    check("t5_no_aborted_rsp", {8'(tot_rsp0 - s_rsp0), 8'(tot_rsp1 - s_rsp1)}, 16'h0);
    r_data = 32'hC3;
    drive_req(0, 1'b1, 32'h8, 32'h77, 4'hF);
    drive_req(1, 1'b0, 32'h7, 32'h0, 4'h0);
    first_rdy = 2'b00; got0 = 0; got1 = 0; r0_resp = 2'bxx; r1_resp = 2'bxx; r1_data = 'x;
    for (int c = 0; c < 40 && !(got0 && got1); c++) begin
      @(negedge ACLK);
      if (first_rdy == 2'b00) first_rdy = {REQ1_READY, REQ0_READY};
      if (REQ0_READY === 1'b1) REQ0_VALID = 0;
      if (REQ1_READY === 1'b1) REQ1_VALID = 0;
      if (RSP0_VALID === 1'b1) begin got0 = 1; r0_resp = RSP0_RESP; end
      if (RSP1_VALID === 1'b1) begin got1 = 1; r1_data = RSP1_RDATA; r1_resp = RSP1_RESP; end
    end
    check("t5_tie_req0_wins", first_rdy, 2'b01);
    check("t5_both_done", {got0, got1}, 2'b11);
    check("t5_rsp0_resp", r0_resp, 2'b00);
    check("t5_rsp1_read", {r1_resp, r1_data}, {2'b00, 32'hC3});

    // Test 6: protocol monitor over the whole run
    repeat (2) @(negedge ACLK);
    check("t6_monitor_errors", mon_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
